// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with optional write-first bypass, optional
// registered read data and a per-register busy scoreboard with population count.
module regfile_mp_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                    iClk,
    input  logic                    iRstN,
    input  logic                    iWriteEn,
    input  logic [AW-1:0]           iRdAddr,
    input  logic [WIDTH-1:0]        iWriteData,
    input  logic [NUM_RD-1:0]       iReadEn,
    input  logic [NUM_RD*AW-1:0]    iRsAddr,
    output logic [NUM_RD*WIDTH-1:0] oRsData,
    output logic [NUM_RD-1:0]       oRsBusy,
    input  logic                    iIssueEn,
    input  logic [AW-1:0]           iIssueAddr,
    input  logic                    iFlush,
    output logic [CW-1:0]           oBusyCnt
);

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    // Addresses past DEPTH and, with ZERO_REG, x0 are treated as non-existent.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic                    wr_ok;
    logic                    iss_ok;
    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_d;
    logic [CW-1:0]           busy_cnt_q;
    logic [CW-1:0]           busy_cnt_d;

    assign wr_ok  = iWriteEn && addr_ok(iRdAddr);
    assign iss_ok = iIssueEn && addr_ok(iIssueAddr);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = (wr_ok && (iRdAddr == AW'(i))) ? iWriteData : regs_q[i];
        end
    end

    // Flush dominates; otherwise a same-cycle issue overrides the writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (iFlush) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (iRdAddr == AW'(i))) begin
                    busy_d[i] = 1'b0;
                end
                if (iss_ok && (iIssueAddr == AW'(i))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign oBusyCnt = busy_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]    addr;
            logic             ok;
            logic             hit;
            logic [WIDTH-1:0] val;

            assign addr = iRsAddr[gi*AW +: AW];
            assign ok   = addr_ok(addr);
            assign hit  = (BYPASS != 0) && iWriteEn && (iRdAddr == addr);

            always_comb begin
                val = '0;
                if (ok) begin
                    val = hit ? iWriteData : regs_q[addr];
                end
            end

            // A write landing this cycle resolves the hazard when bypassing.
            assign oRsBusy[gi] = ok && busy_q[addr] && !hit;

            if (REG_OUT != 0) begin : g_q
                logic [WIDTH-1:0] rs_data_q;
                logic [WIDTH-1:0] rs_data_d;

                always_comb begin
                    rs_data_d = iReadEn[gi] ? val : rs_data_q;
                end

                always_ff @(posedge iClk or negedge iRstN) begin
                    if (!iRstN) begin
                        rs_data_q <= '0;
                    end else begin
                        rs_data_q <= rs_data_d;
                    end
                end

                assign oRsData[gi*WIDTH +: WIDTH] = rs_data_q;
            end else begin : g_c
                assign oRsData[gi*WIDTH +: WIDTH] = iReadEn[gi] ? val : '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a default instance (bypass, combinational reads) and a
// DEPTH=24, NUM_RD=3, no-bypass, registered-read instance driven in lockstep.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_we, a_ie, a_fl;
    logic [4:0]  a_wa, a_ia;
    logic [31:0] a_wd;
    logic [1:0]  a_re;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rb;
    logic [5:0]  a_cnt;

    logic        b_we, b_ie, b_fl;
    logic [4:0]  b_wa, b_ia;
    logic [31:0] b_wd;
    logic [2:0]  b_re;
    logic [14:0] b_ra;
    logic [95:0] b_rd;
    logic [2:0]  b_rb;
    logic [4:0]  b_cnt;

    regfile_mp_sb #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .REG_OUT(0)) dut_a (
        .iClk(clk), .iRstN(rst_n), .iWriteEn(a_we), .iRdAddr(a_wa), .iWriteData(a_wd),
        .iReadEn(a_re), .iRsAddr(a_ra), .oRsData(a_rd), .oRsBusy(a_rb),
        .iIssueEn(a_ie), .iIssueAddr(a_ia), .iFlush(a_fl), .oBusyCnt(a_cnt)
    );

    regfile_mp_sb #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1), .BYPASS(0), .REG_OUT(1)) dut_b (
        .iClk(clk), .iRstN(rst_n), .iWriteEn(b_we), .iRdAddr(b_wa), .iWriteData(b_wd),
        .iReadEn(b_re), .iRsAddr(b_ra), .oRsData(b_rd), .oRsBusy(b_rb),
        .iIssueEn(b_ie), .iIssueAddr(b_ia), .iFlush(b_fl), .oBusyCnt(b_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] v;
    } item_t;

    item_t       exp_q [$];
    logic [31:0] obs_q [$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [31:0] ma  [32];
    bit          mba [32];
    logic [31:0] mb  [24];
    bit          mbb [24];
    logic [31:0] mob [3];

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin ma[i] = '0; mba[i] = 0; end
        for (int i = 0; i < 24; i++) begin mb[i] = '0; mbb[i] = 0; end
        for (int i = 0; i < 3; i++) mob[i] = '0;
    endfunction

    function automatic logic [31:0] a_val(input int ad);
        if (ad == 0) return '0;
        if (a_we && int'(a_wa) == ad) return a_wd;
        return ma[ad];
    endfunction

    function automatic logic [31:0] b_val(input int ad);
        if (ad == 0 || ad >= 24) return '0;
        return mb[ad];
    endfunction

    // Record expected (from the model) and observed values for this cycle.
    function automatic void observe(input string tag);
        int ad;
        int cnt;
        for (int p = 0; p < 2; p++) begin
            ad = int'(a_ra[p*5 +: 5]);
            exp_q.push_back('{$sformatf("%s/a_rd%0d", tag, p), a_re[p] ? a_val(ad) : 32'h0});
            obs_q.push_back(a_rd[p*32 +: 32]);
            exp_q.push_back('{$sformatf("%s/a_busy%0d", tag, p),
                              32'((ad != 0) && mba[ad] && !(a_we && int'(a_wa) == ad))});
            obs_q.push_back(32'(a_rb[p]));
        end
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(mba[i]);
        exp_q.push_back('{$sformatf("%s/a_cnt", tag), 32'(cnt)});
        obs_q.push_back(32'(a_cnt));
        for (int p = 0; p < 3; p++) begin
            ad = int'(b_ra[p*5 +: 5]);
            exp_q.push_back('{$sformatf("%s/b_rd%0d", tag, p), mob[p]});
            obs_q.push_back(b_rd[p*32 +: 32]);
            exp_q.push_back('{$sformatf("%s/b_busy%0d", tag, p),
                              32'((ad != 0) && (ad < 24) && mbb[(ad < 24) ? ad : 0])});
            obs_q.push_back(32'(b_rb[p]));
        end
        cnt = 0;
        for (int i = 0; i < 24; i++) cnt += int'(mbb[i]);
        exp_q.push_back('{$sformatf("%s/b_cnt", tag), 32'(cnt)});
        obs_q.push_back(32'(b_cnt));
    endfunction

    // Sample at negedge, then advance the model across the coming posedge.
    task automatic cycle(input string tag);
        int wa;
        int ia;
        @(negedge clk);
        observe(tag);
        if (rst_n) begin
            wa = int'(a_wa); ia = int'(a_ia);
            if (a_fl) begin
                for (int i = 0; i < 32; i++) mba[i] = 0;
            end else begin
                if (a_we && wa != 0) mba[wa] = 0;
                if (a_ie && ia != 0) mba[ia] = 1;
            end
            if (a_we && wa != 0) ma[wa] = a_wd;
            for (int p = 0; p < 3; p++) begin
                if (b_re[p]) mob[p] = b_val(int'(b_ra[p*5 +: 5]));
            end
            wa = int'(b_wa); ia = int'(b_ia);
            if (b_fl) begin
                for (int i = 0; i < 24; i++) mbb[i] = 0;
            end else begin
                if (b_we && wa != 0 && wa < 24) mbb[wa] = 0;
                if (b_ie && ia != 0 && ia < 24) mbb[ia] = 1;
            end
            if (b_we && wa != 0 && wa < 24) mb[wa] = b_wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 0; a_ie = 0; a_fl = 0; a_wa = '0; a_ia = '0; a_wd = '0;
        b_we = 0; b_ie = 0; b_fl = 0; b_wa = '0; b_ia = '0; b_wd = '0;
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input bit ie, input int ia, input bit fl);
        a_we = we; a_wa = 5'(wa); a_wd = wd; a_ie = ie; a_ia = 5'(ia); a_fl = fl;
        b_we = we; b_wa = 5'(wa); b_wd = wd; b_ie = ie; b_ia = 5'(ia); b_fl = fl;
    endtask

    task automatic reads(input logic [1:0] are, input int a0, input int a1,
                         input logic [2:0] bre, input int b0, input int b1, input int b2);
        a_re = are; a_ra = {5'(a1), 5'(a0)};
        b_re = bre; b_ra = {5'(b2), 5'(b1), 5'(b0)};
    endtask

    task automatic drain();
        item_t       e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h0BAD_0001, 1, 2, 0); reads(2'b11, 1, 2, 3'b111, 1, 2, 3); cycle("rst_dirty0");
        drive(1, 2, 32'h0BAD_0002, 1, 3, 0); cycle("rst_dirty1");
        idle();
        rst_n = 1'b0;
        model_clear();
        cycle("rst_active");
        rst_n = 1'b1;
        cycle("rst_release");
        drain();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_write_read();
        reads(2'b00, 0, 0, 3'b000, 0, 0, 0);
        drive(1, 1, 32'hDEAD_BEEF, 0, 0, 0); cycle("wr_x1");
        drive(1, 5, 32'hCAFE_BABE, 0, 0, 0); cycle("wr_x5");
        drive(1, 0, 32'h1234_5678, 0, 0, 0); cycle("wr_x0");
        idle();
        reads(2'b11, 1, 5, 3'b111, 1, 5, 0); cycle("rd_1_5");
        reads(2'b01, 0, 5, 3'b000, 1, 5, 0); cycle("rd_x0");
        reads(2'b10, 0, 1, 3'b000, 0, 0, 0); cycle("rd_en_gate");
        drain();
        $display("test_write_read done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_bypass();
        drive(1, 10, 32'hABCD_1234, 0, 0, 0);
        reads(2'b11, 10, 10, 3'b111, 10, 10, 1); cycle("byp_same");
        idle(); cycle("byp_after");
        drain();
        $display("test_bypass done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reg_out();
        idle(); reads(2'b01, 1, 0, 3'b001, 1, 0, 0); cycle("ro_read");
        drive(1, 1, 32'h1111_1111, 0, 0, 0); reads(2'b00, 1, 0, 3'b000, 1, 0, 0); cycle("ro_write");
        idle(); cycle("ro_hold");
        reads(2'b01, 1, 0, 3'b001, 1, 0, 0); cycle("ro_reread");
        idle(); cycle("ro_new");
        drain();
        $display("test_reg_out done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_scoreboard();
        reads(2'b00, 3, 0, 3'b000, 3, 0, 4);
        drive(0, 0, 0, 1, 3, 0); cycle("sb_issue3");
        idle(); cycle("sb_busy3");
        drive(1, 3, 32'h3333_0000, 1, 3, 0); cycle("sb_wr_iss3");
        idle(); cycle("sb_still3");
        drive(1, 3, 32'h3333_0001, 0, 0, 0); cycle("sb_wr3");
        idle(); cycle("sb_clear3");
        drive(0, 0, 0, 1, 0, 0); cycle("sb_issue0");
        idle(); cycle("sb_none");
        drain();
        $display("test_scoreboard done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_flush();
        reads(2'b00, 2, 4, 3'b000, 2, 4, 7);
        drive(0, 0, 0, 1, 2, 0); cycle("fl_iss2");
        drive(0, 0, 0, 1, 4, 0); cycle("fl_iss4");
        drive(0, 0, 0, 1, 6, 0); cycle("fl_iss6");
        idle(); reads(2'b00, 6, 7, 3'b000, 2, 6, 7); cycle("fl_cnt3");
        drive(0, 0, 0, 1, 7, 1); cycle("fl_flush");
        idle(); cycle("fl_empty");
        drain();
        $display("test_flush done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_invalid_addr();
        reads(2'b00, 30, 23, 3'b000, 30, 23, 24);
        drive(1, 30, 32'h5555_5555, 1, 30, 0); cycle("inv_wr30");
        drive(1, 23, 32'h2323_2323, 1, 23, 0); cycle("inv_wr23");
        drive(0, 0, 0, 1, 24, 0); reads(2'b11, 30, 23, 3'b111, 30, 23, 24); cycle("inv_read");
        idle(); cycle("inv_result");
        drive(0, 0, 0, 0, 0, 1); cycle("inv_flush");
        idle(); cycle("inv_done");
        drain();
        $display("test_invalid_addr done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        reads(2'b00, 0, 0, 3'b000, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_reg_out();
        test_scoreboard();
        test_flush();
        test_invalid_addr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
